// File: rtl/riscv_pipeline_pkg.sv
// riscv_pipeline_pkg: shared ALU codes, register constants and the execute-stage control bundle
package riscv_pipeline_pkg;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Width-independent half of the execute bundle; XLEN-wide data lives beside it in the top.
    typedef struct packed {
        logic       valid;
        logic [3:0] alu_op;
        logic       is_load;
        logic       write_enable;
        logic [4:0] rd;
    } execute_bundle_t;

    localparam execute_bundle_t EXECUTE_NOP = '{
        valid: 1'b0, alu_op: ALU_NOP, is_load: 1'b0, write_enable: 1'b0, rd: REG_ZERO
    };

endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: flags a decode instruction that reads the destination of a load now in execute
module load_use_detector
    import riscv_pipeline_pkg::*;
(
    input  logic       execute_valid,
    input  logic       execute_is_load,
    input  logic [4:0] execute_rd,
    input  logic       decode_valid,
    input  logic [4:0] decode_register_number_a,
    input  logic [4:0] decode_register_number_b,
    input  logic       decode_uses_a,
    input  logic       decode_uses_b,
    output logic       load_use
);

    logic hit_a, hit_b;

    assign hit_a = decode_uses_a & (decode_register_number_a == execute_rd);
    assign hit_b = decode_uses_b & (decode_register_number_b == execute_rd);
    assign load_use = execute_valid & execute_is_load & (execute_rd != REG_ZERO)
                    & decode_valid & (hit_a | hit_b);

endmodule

// File: rtl/execute_issue_register.sv
// execute_issue_register: decode-to-execute register with load-use bubble, redirect flush and freeze.
// Optional ISSUE_STATS_EN adds bubble_count / flush_count outputs.
module execute_issue_register
    import riscv_pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pipeline_freeze,
    input  logic            execute_redirect,
    input  logic            decode_valid,
    input  logic [XLEN-1:0] decode_pc,
    input  logic [4:0]      decode_register_number_a,
    input  logic [4:0]      decode_register_number_b,
    input  logic            decode_uses_a,
    input  logic            decode_uses_b,
    input  logic [XLEN-1:0] decode_operand_a,
    input  logic [XLEN-1:0] decode_operand_b,
    input  logic [XLEN-1:0] decode_immediate,
    input  logic [4:0]      decode_destination_register_number,
    input  logic            decode_write_enable,
    input  logic            decode_is_load,
    input  logic [3:0]      decode_alu_op,
    output logic            hazard_stall,
    output logic            execute_valid,
    output logic [XLEN-1:0] execute_pc,
    output logic [XLEN-1:0] execute_operand_a,
    output logic [XLEN-1:0] execute_operand_b,
    output logic [XLEN-1:0] execute_immediate,
    output logic [3:0]      execute_alu_op,
    output logic            execute_is_load,
    output logic [4:0]      execute_destination_register_number,
`ifdef ISSUE_STATS_EN
    output logic [31:0]     bubble_count,
    output logic [31:0]     flush_count,
`endif
    output logic            execute_forward_enable
);

    execute_bundle_t ctrl_q, ctrl_d;
    logic [XLEN-1:0] pc_q, operand_a_q, operand_b_q, immediate_q;
    logic            load_use, kill;

    load_use_detector u_load_use_detector (
        .execute_valid            (ctrl_q.valid),
        .execute_is_load          (ctrl_q.is_load),
        .execute_rd               (ctrl_q.rd),
        .decode_valid             (decode_valid),
        .decode_register_number_a (decode_register_number_a),
        .decode_register_number_b (decode_register_number_b),
        .decode_uses_a            (decode_uses_a),
        .decode_uses_b            (decode_uses_b),
        .load_use                 (load_use)
    );

    assign hazard_stall = load_use & ~execute_redirect & ~pipeline_freeze;
    assign kill = execute_redirect | load_use;

    always_comb begin
        ctrl_d = EXECUTE_NOP;
        if (!kill) begin
            ctrl_d.valid        = decode_valid;
            ctrl_d.alu_op       = decode_alu_op;
            ctrl_d.is_load      = decode_valid & decode_is_load;
            ctrl_d.write_enable = decode_valid & decode_write_enable;
            ctrl_d.rd           = decode_destination_register_number;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q      <= EXECUTE_NOP;
            pc_q        <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            immediate_q <= '0;
        end else if (!pipeline_freeze) begin
            ctrl_q      <= ctrl_d;
            pc_q        <= kill ? '0 : decode_pc;
            operand_a_q <= kill ? '0 : decode_operand_a;
            operand_b_q <= kill ? '0 : decode_operand_b;
            immediate_q <= kill ? '0 : decode_immediate;
        end
    end

`ifdef ISSUE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else if (!pipeline_freeze) begin
            bubble_count <= bubble_count + {31'd0, load_use & ~execute_redirect};
            flush_count  <= flush_count + {31'd0, execute_redirect};
        end
    end
`endif

    assign execute_valid                       = ctrl_q.valid;
    assign execute_pc                          = pc_q;
    assign execute_operand_a                   = operand_a_q;
    assign execute_operand_b                   = operand_b_q;
    assign execute_immediate                   = immediate_q;
    assign execute_alu_op                      = ctrl_q.alu_op;
    assign execute_is_load                     = ctrl_q.is_load;
    assign execute_destination_register_number = ctrl_q.rd;
    // Load results only become forwardable from memory access.
    assign execute_forward_enable = ctrl_q.valid & ctrl_q.write_enable & ~ctrl_q.is_load
                                  & (ctrl_q.rd != REG_ZERO);

endmodule
